// File: rtl/mpsoc_mem_copy_pkg.sv
// Shared types and constants for the word-copy Avalon-MM initiator.
package mpsoc_mem_copy_pkg;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } state_e;

  // Both byte addresses must sit on a 32-bit word boundary.
  function automatic logic words_aligned(input logic [1:0] src_lsb, input logic [1:0] dst_lsb);
    return (src_lsb == 2'b00) && (dst_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mpsoc_copy_addr_gen.sv
// Source/destination address walker plus remaining and completed word counters.
module mpsoc_copy_addr_gen
  import mpsoc_mem_copy_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] src_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic [LEN_W-1:0]  words_done_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  remain_q, done_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q      <= '0;
      dst_q      <= '0;
      remain_q   <= '0;
      done_cnt_q <= '0;
    end else if (load_i) begin
      src_q      <= src_i;
      dst_q      <= dst_i;
      remain_q   <= len_i;
      done_cnt_q <= '0;
    end else if (step_i) begin
      // Addresses wrap naturally at 2^ADDR_W.
      src_q      <= src_q + ADDR_W'(WORD_BYTES);
      dst_q      <= dst_q + ADDR_W'(WORD_BYTES);
      remain_q   <= remain_q - LEN_W'(1);
      done_cnt_q <= done_cnt_q + LEN_W'(1);
    end
  end

  assign src_o        = src_q;
  assign dst_o        = dst_q;
  assign words_done_o = done_cnt_q;
  assign last_o       = (remain_q == LEN_W'(1));

endmodule

// File: rtl/mpsoc_mem_copy_master.sv
// Avalon-MM initiator copying 32-bit words one at a time (read, then write).
// Define MPSOC_MEM_COPY_CHECKSUM_EN to add the checksum output.
module mpsoc_mem_copy_master
  import mpsoc_mem_copy_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
`ifdef MPSOC_MEM_COPY_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              abort_q, abort_d;
  logic [31:0]       data_q, data_d;
  logic              load, step, last;
  logic [ADDR_W-1:0] cur_src, cur_dst;
  logic              start_ok;

  assign start_ok = words_aligned(src_addr[1:0], dst_addr[1:0]);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    error_d = error_q;
    abort_d = abort_q | (abort & (state_q != ST_IDLE));
    data_d  = data_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          done_d = 1'b1;
          if (!start_ok) begin
            error_d = 1'b1;
          end else begin
            error_d = 1'b0;
            load    = 1'b1;
            if (len_words != '0) begin
              done_d  = 1'b0;
              state_d = ST_RD_REQ;
            end
          end
        end
      end
      ST_RD_REQ: begin
        if (!avm_waitrequest) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (avm_readdatavalid) begin
          data_d  = avm_readdata;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        // Abort is only honoured here, once the current word has landed.
        if (!avm_waitrequest) begin
          step = 1'b1;
          if (last || abort_q || abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      abort_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      error_q <= error_d;
      abort_q <= abort_d;
      data_q  <= data_d;
    end
  end

  mpsoc_copy_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load),
    .step_i       (step),
    .src_i        (src_addr),
    .dst_i        (dst_addr),
    .len_i        (len_words),
    .src_o        (cur_src),
    .dst_o        (cur_dst),
    .words_done_o (words_done),
    .last_o       (last)
  );

`ifdef MPSOC_MEM_COPY_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      sum_q <= '0;
    end else if (step) begin
      sum_q <= sum_q + data_q;
    end
  end

  assign checksum = sum_q;
`endif

  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign error          = error_q;
  assign avm_read       = (state_q == ST_RD_REQ);
  assign avm_write      = (state_q == ST_WR_REQ);
  assign avm_byteenable = (avm_read || avm_write) ? BE_ALL : 4'b0000;
  assign avm_writedata  = avm_write ? data_q : 32'h0;

  always_comb begin
    avm_address = '0;
    case (state_q)
      ST_RD_REQ: avm_address = cur_src;
      ST_WR_REQ: avm_address = cur_dst;
      default:   avm_address = '0;
    endcase
  end

endmodule
